// File: rtl/retire_stage.sv
// -----------------------------------------------------------------------------
// retire_stage
//   In-order commit stage at the head of the reorder buffer. Each cycle it
//   looks at the N oldest ROB entries, decides how many retire, returns the
//   previous physical registers to the free list and updates the architectural
//   map table. A retiring mispredicted branch produces a one-cycle flush pulse;
//   a retiring halt parks the stage in a sticky halted state until reset.
//
// Optional feature macro: RETIRE_STATS_EN
//   When defined, adds retired_count (64 b) and flush_count (32 b) outputs.
//
// Ports
//   clock              in   single clock, all state updates on posedge
//   reset              in   synchronous, active-high
//   rob_outputs        in   N packed entries, entry i at [i*PKT_W +: PKT_W],
//                           entry 0 oldest. Entry layout (MSB..LSB):
//                           {complete, mispredict, halt, has_dest,
//                            R_dest[AREG_BITS], T[PREG_BITS], T_old[PREG_BITS]}
//   rob_outputs_valid  in   number of valid entries from index 0 (clamped to N)
//   num_retiring       out  entries the ROB clears at the next edge
//   free_valid         out  per-slot strobe: return free_preg[i] to free list
//   free_preg          out  T_old of retiring slot i
//   amt_we             out  per-slot architectural map write enable
//   amt_idx            out  R_dest of slot i
//   amt_preg           out  T of slot i
//   flush              out  registered, one-cycle pulse after a mispredict retires
//   halted             out  registered, sticky after a halt retires
//   retired_count      out  (RETIRE_STATS_EN) running total of retired entries
//   flush_count        out  (RETIRE_STATS_EN) number of RUN->FLUSH transitions
// -----------------------------------------------------------------------------
module retire_stage #(
   parameter int N         = 3,
   parameter int PREG_BITS = 6,
   parameter int AREG_BITS = 5,
   localparam int CNT_W    = $clog2(N + 1),
   localparam int PKT_W    = 4 + AREG_BITS + 2 * PREG_BITS
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [N*PKT_W-1:0]         rob_outputs,
   input  logic [CNT_W-1:0]           rob_outputs_valid,
   output logic [CNT_W-1:0]           num_retiring,
   output logic [N-1:0]               free_valid,
   output logic [N*PREG_BITS-1:0]     free_preg,
   output logic [N-1:0]               amt_we,
   output logic [N*AREG_BITS-1:0]     amt_idx,
   output logic [N*PREG_BITS-1:0]     amt_preg,
   output logic                       flush,
   output logic                       halted
`ifdef RETIRE_STATS_EN
   ,
   output logic [63:0]                retired_count,
   output logic [31:0]                flush_count
`endif
);

   // Field offsets inside one packed ROB entry
   localparam int OFF_TOLD = 0;
   localparam int OFF_T    = PREG_BITS;
   localparam int OFF_RD   = 2 * PREG_BITS;
   localparam int OFF_HD   = 2 * PREG_BITS + AREG_BITS;
   localparam int OFF_HALT = OFF_HD + 1;
   localparam int OFF_MP   = OFF_HD + 2;
   localparam int OFF_CMP  = OFF_HD + 3;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_FLUSH = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic             flush_q, flush_d;
   logic             halted_q, halted_d;
   logic [CNT_W-1:0] valid_lim;
   logic             run_ok;
   logic             stop;
   logic             hit_halt;
   logic             hit_mp;
`ifdef RETIRE_STATS_EN
   logic [63:0]      retired_count_q, retired_count_d;
   logic [31:0]      flush_count_q, flush_count_d;
`endif

   // Retire scan: walk slots oldest-first, stop at the first incomplete slot
   // or just after a retiring halt/mispredict.
   always_comb begin
      num_retiring = '0;
      free_valid   = '0;
      free_preg    = '0;
      amt_we       = '0;
      amt_idx      = '0;
      amt_preg     = '0;
      stop         = 1'b0;
      hit_halt     = 1'b0;
      hit_mp       = 1'b0;
      valid_lim    = (rob_outputs_valid > CNT_W'(N)) ? CNT_W'(N) : rob_outputs_valid;
      // Reset and the FLUSH/HALT states suppress all retirement
      run_ok       = (state_q == ST_RUN) && !reset;
      for (int i = 0; i < N; i++) begin
         if (run_ok && !stop && (CNT_W'(i) < valid_lim) && rob_outputs[i*PKT_W + OFF_CMP]) begin
            num_retiring = num_retiring + CNT_W'(1);
            // Register x0 and destination-less ops retire without touching
            // the free list or map table
            if (rob_outputs[i*PKT_W + OFF_HD] &&
                (rob_outputs[i*PKT_W + OFF_RD +: AREG_BITS] != {AREG_BITS{1'b0}})) begin
               free_valid[i]                          = 1'b1;
               free_preg[i*PREG_BITS +: PREG_BITS]    = rob_outputs[i*PKT_W + OFF_TOLD +: PREG_BITS];
               amt_we[i]                              = 1'b1;
               amt_idx[i*AREG_BITS +: AREG_BITS]      = rob_outputs[i*PKT_W + OFF_RD +: AREG_BITS];
               amt_preg[i*PREG_BITS +: PREG_BITS]     = rob_outputs[i*PKT_W + OFF_T +: PREG_BITS];
            end else begin
               free_valid[i] = 1'b0;
            end
            // Halt wins over mispredict on the same slot
            if (rob_outputs[i*PKT_W + OFF_HALT]) begin
               hit_halt = 1'b1;
               stop     = 1'b1;
            end else if (rob_outputs[i*PKT_W + OFF_MP]) begin
               hit_mp = 1'b1;
               stop   = 1'b1;
            end else begin
               stop = stop;
            end
         end else begin
            stop = 1'b1;
         end
      end
   end

   // Next-state logic for RUN / FLUSH / HALT and the registered status flags
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (hit_halt) begin
               state_d = ST_HALT;
            end else if (hit_mp) begin
               state_d = ST_FLUSH;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_FLUSH: state_d = ST_RUN;
         ST_HALT:  state_d = ST_HALT;
         default:  state_d = ST_RUN;
      endcase
      flush_d  = (state_d == ST_FLUSH);
      halted_d = (state_d == ST_HALT);
   end

`ifdef RETIRE_STATS_EN
   // Statistics: retirement is already zero in HALT, so counts hold there
   always_comb begin
      retired_count_d = retired_count_q + 64'(num_retiring);
      if ((state_q == ST_RUN) && (state_d == ST_FLUSH)) begin
         flush_count_d = flush_count_q + 32'd1;
      end else begin
         flush_count_d = flush_count_q;
      end
   end
`endif

   // State and status registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q         <= ST_RUN;
         flush_q         <= 1'b0;
         halted_q        <= 1'b0;
`ifdef RETIRE_STATS_EN
         retired_count_q <= 64'd0;
         flush_count_q   <= 32'd0;
`endif
      end else begin
         state_q         <= state_d;
         flush_q         <= flush_d;
         halted_q        <= halted_d;
`ifdef RETIRE_STATS_EN
         retired_count_q <= retired_count_d;
         flush_count_q   <= flush_count_d;
`endif
      end
   end

   assign flush  = flush_q;
   assign halted = halted_q;
`ifdef RETIRE_STATS_EN
   assign retired_count = retired_count_q;
   assign flush_count   = flush_count_q;
`endif

endmodule

// File: tb/tb_retire_stage.sv
// -----------------------------------------------------------------------------
// tb_retire_stage
//   Self-checking bench for retire_stage (N=3). A behavioural model derives
//   the expected retirement from the ROB entries the bench drives; a compare
//   process checks every output on every negedge. Directed scenarios add
//   hand-computed expectations, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_retire_stage;
   localparam int N  = 3;
   localparam int PB = 6;
   localparam int AB = 5;
   localparam int CW = 2;
   localparam int PW = 4 + AB + 2 * PB;

   logic              clock = 1'b0;
   logic              reset;
   logic [N*PW-1:0]   rob_outputs;
   logic [CW-1:0]     rob_outputs_valid;
   logic [CW-1:0]     num_retiring;
   logic [N-1:0]      free_valid;
   logic [N*PB-1:0]   free_preg;
   logic [N-1:0]      amt_we;
   logic [N*AB-1:0]   amt_idx;
   logic [N*PB-1:0]   amt_preg;
   logic              flush;
   logic              halted;
`ifdef RETIRE_STATS_EN
   logic [63:0]       retired_count;
   logic [31:0]       flush_count;
`endif

   retire_stage #(.N(N), .PREG_BITS(PB), .AREG_BITS(AB)) dut (
      .clock             (clock),
      .reset             (reset),
      .rob_outputs       (rob_outputs),
      .rob_outputs_valid (rob_outputs_valid),
      .num_retiring      (num_retiring),
      .free_valid        (free_valid),
      .free_preg         (free_preg),
      .amt_we            (amt_we),
      .amt_idx           (amt_idx),
      .amt_preg          (amt_preg),
      .flush             (flush),
      .halted            (halted)
`ifdef RETIRE_STATS_EN
      ,
      .retired_count     (retired_count),
      .flush_count       (flush_count)
`endif
   );

   always #5 clock = ~clock;

   // Bench-side view of the driven ROB entries
   logic          e_c[N], e_m[N], e_h[N], e_hd[N];
   logic [AB-1:0] e_rd[N];
   logic [PB-1:0] e_t[N], e_to[N];
   int            e_valid;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Model state
   logic            m_flush  = 1'b0;
   logic            m_halted = 1'b0;
   longint unsigned m_ret    = 0;
   int unsigned     m_fl     = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic apply();
      for (int i = 0; i < N; i++)
         rob_outputs[i*PW +: PW] = {e_c[i], e_m[i], e_h[i], e_hd[i], e_rd[i], e_t[i], e_to[i]};
      rob_outputs_valid = CW'(e_valid);
   endtask

   task automatic clr_entries();
      for (int i = 0; i < N; i++) begin
         e_c[i]  = 1'b1;
         e_m[i]  = 1'b0;
         e_h[i]  = 1'b0;
         e_hd[i] = 1'b1;
         e_rd[i] = AB'(i + 1);
         e_t[i]  = PB'(10 + i);
         e_to[i] = PB'(20 + i);
      end
      e_valid = 3;
   endtask

   // Number of leading complete entries, cut just after the first halt or mispredict
   function automatic int model_count();
      int  n;
      int  k;
      bit  done;
      n    = (e_valid > N) ? N : e_valid;
      k    = 0;
      done = 1'b0;
      while (!done && k < n) begin
         if (!e_c[k]) done = 1'b1;
         else begin
            k++;
            if (e_h[k-1] || e_m[k-1]) done = 1'b1;
         end
      end
      return k;
   endfunction

   function automatic bit model_halt();
      int k = model_count();
      return (k > 0) && e_h[k-1];
   endfunction

   function automatic bit model_mp();
      int k = model_count();
      return (k > 0) && e_m[k-1] && !e_h[k-1];
   endfunction

   // Model state advance on each active edge
   always @(posedge clock) begin
      if (reset) begin
         m_flush  <= 1'b0;
         m_halted <= 1'b0;
         m_ret    <= 0;
         m_fl     <= 0;
      end else if (!m_flush && !m_halted) begin
         m_ret    <= m_ret + longint'(model_count());
         m_halted <= model_halt();
         m_flush  <= model_mp();
         if (model_mp()) m_fl <= m_fl + 1;
      end else begin
         m_flush <= 1'b0;
      end
   end

   task automatic compare_cycle();
      int            k;
      logic [N-1:0]  ev;
      logic [N*PB-1:0] efp, eap;
      logic [N*AB-1:0] eai;
      k   = (reset || m_flush || m_halted) ? 0 : model_count();
      ev  = '0;
      efp = '0;
      eap = '0;
      eai = '0;
      for (int i = 0; i < k; i++) begin
         if (e_hd[i] && e_rd[i] != '0) begin
            ev[i]           = 1'b1;
            efp[i*PB +: PB] = e_to[i];
            eap[i*PB +: PB] = e_t[i];
            eai[i*AB +: AB] = e_rd[i];
         end
      end
      chk("num_retiring", 64'(num_retiring), 64'(k));
      chk("free_valid",   64'(free_valid),   64'(ev));
      chk("free_preg",    64'(free_preg),    64'(efp));
      chk("amt_we",       64'(amt_we),       64'(ev));
      chk("amt_idx",      64'(amt_idx),      64'(eai));
      chk("amt_preg",     64'(amt_preg),     64'(eap));
      chk("flush",        64'(flush),        64'(m_flush));
      chk("halted",       64'(halted),       64'(m_halted));
`ifdef RETIRE_STATS_EN
      chk("retired_count", retired_count,    m_ret);
      chk("flush_count",   64'(flush_count), 64'(m_fl));
`endif
   endtask

   always @(negedge clock) compare_cycle();

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic look();
      @(negedge clock);
   endtask

   int halt_cnt = 0;

   initial begin
      // Reset with complete entries present: nothing may retire
      reset = 1'b1;
      clr_entries();
      apply();
      look();
      chk("rst_num", 64'(num_retiring), 64'd0);
      chk("rst_fv",  64'(free_valid),   64'd0);
      chk("rst_we",  64'(amt_we),       64'd0);
      step();
      look();
      chk("rst_flush",  64'(flush),  64'd0);
      chk("rst_halted", 64'(halted), 64'd0);
      step();
      reset = 1'b0;

      // Partial completion: slots 0,1 retire
      clr_entries();
      e_c[2] = 1'b0;
      apply();
      look();
      chk("t1_num", 64'(num_retiring), 64'd2);
      chk("t1_fv",  64'(free_valid),   64'b011);
      chk("t1_we",  64'(amt_we),       64'b011);
      chk("t1_fp1", 64'(free_preg[PB +: PB]), 64'd21);
      chk("t1_ap1", 64'(amt_preg[PB +: PB]),  64'd11);
      step();

      // Mispredict in slot 1: two retire, then a single flush cycle
      clr_entries();
      e_m[1] = 1'b1;
      apply();
      look();
      chk("t2_num", 64'(num_retiring), 64'd2);
      step();
      e_m[1] = 1'b0;
      apply();
      look();
      chk("t2_flush", 64'(flush), 64'd1);
      chk("t2_fnum",  64'(num_retiring), 64'd0);
      step();
      look();
      chk("t2_flush_off", 64'(flush), 64'd0);
      chk("t2_resume",    64'(num_retiring), 64'd3);
      step();

      // Halt and mispredict on slot 0: halt wins
      clr_entries();
      e_h[0] = 1'b1;
      e_m[0] = 1'b1;
      apply();
      look();
      chk("t3_num", 64'(num_retiring), 64'd1);
      step();
      clr_entries();
      apply();
      for (int c = 0; c < 10; c++) begin
         look();
         chk("t3_halted", 64'(halted), 64'd1);
         chk("t3_noflush", 64'(flush), 64'd0);
         chk("t3_num0", 64'(num_retiring), 64'd0);
         step();
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      look();
      chk("t3_unhalt", 64'(halted), 64'd0);
      step();

      // x0 destination and no-destination slots retire without strobes
      clr_entries();
      e_rd[0] = '0;
      e_hd[1] = 1'b0;
      apply();
      look();
      chk("t5_num", 64'(num_retiring), 64'd3);
      chk("t5_fv",  64'(free_valid),   64'b100);
      chk("t5_we",  64'(amt_we),       64'b100);
      step();

      // Reset during the flush cycle
      clr_entries();
      e_m[0] = 1'b1;
      apply();
      look();
      chk("t6_num", 64'(num_retiring), 64'd1);
      step();
      e_m[0] = 1'b0;
      reset  = 1'b1;
      apply();
      look();
      chk("t6_flush",   64'(flush),        64'd1);
      chk("t6_rst_num", 64'(num_retiring), 64'd0);
      step();
      reset = 1'b0;
      look();
      chk("t6_flush_off", 64'(flush),        64'd0);
      chk("t6_num3",      64'(num_retiring), 64'd3);
`ifdef RETIRE_STATS_EN
      chk("t6_rc", retired_count, 64'd0);
      chk("t6_fc", 64'(flush_count), 64'd0);
`endif
      step();

      // Empty ROB for five cycles, then two complete entries
      reset   = 1'b1;
      e_valid = 0;
      apply();
      step();
      reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         look();
         chk("t7_empty", 64'(num_retiring), 64'd0);
         step();
      end
      e_valid = 2;
      apply();
      look();
      chk("t7_num2", 64'(num_retiring), 64'd2);
      step();
      e_valid = 0;
      apply();
      look();
`ifdef RETIRE_STATS_EN
      chk("t7_rc", retired_count, 64'd2);
`endif
      chk("t7_after", 64'(num_retiring), 64'd0);
      step();

      // Randomized run
      for (int c = 0; c < 3000; c++) begin
         halt_cnt = m_halted ? halt_cnt + 1 : 0;
         reset = ($urandom_range(99) < 2) || (halt_cnt > 12);
         for (int i = 0; i < N; i++) begin
            e_c[i]  = ($urandom_range(9) < 8);
            e_m[i]  = ($urandom_range(9) == 0);
            e_h[i]  = ($urandom_range(39) == 0);
            e_hd[i] = ($urandom_range(3) != 0);
            e_rd[i] = AB'($urandom);
            e_t[i]  = PB'($urandom);
            e_to[i] = PB'($urandom);
         end
         e_valid = $urandom_range(3);
         apply();
         step();
      end
      reset = 1'b0;
      look();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/retire_stage.md
# retire_stage

In-order commit stage at the head end of the reorder buffer, and the consumer of the ROB's retire-side interface. Each cycle it examines the up-to-N oldest ROB entries and tells the ROB how many to clear. For each retired entry it returns the previous physical register to the free list and updates the architectural map table. It converts a retiring mispredicted branch into a one-cycle pipeline flush and a retiring halt into a sticky halted state.

## Interface
Parameters:
- N, `N: superscalar width; entry 0 is the oldest.
- PREG_BITS, `PHYS_REG_SZ_BITS: physical register index width.
- AREG_BITS, 5: architectural register index width.

Ports (clock and reset first):
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- rob_outputs  in  N x ROB_PACKET  oldest N ROB entries, in order; fields used are complete, mispredict, halt, has_dest, R_dest, T, T_old.
- rob_outputs_valid  in  `NUM_SCALAR_BITS  count of valid entries from index 0; values above N are clamped to N.
- num_retiring  out  `NUM_SCALAR_BITS  entries the ROB clears at the next edge.
- free_valid  out  N  per-slot strobe: return free_preg[i] to the free list.
- free_preg  out  N x PREG_BITS  T_old of retiring slot i.
- amt_we  out  N  per-slot architectural map write enable.
- amt_idx  out  N x AREG_BITS  R_dest of slot i.
- amt_preg  out  N x PREG_BITS  T of slot i.
- flush  out  1  registered; high exactly one cycle after a mispredicted branch retires.
- halted  out  1  registered; sticky after a halt retires.

## Operation
- FSM states: RUN, FLUSH, HALT. Reset enters RUN.
- RUN, retire scan over slot i = 0..min(valid,N)-1:
  - Slot i retires iff all slots below it retired and rob_outputs[i].complete = 1.
  - Scan stops after the first slot that is incomplete.
  - Scan stops after a retiring slot whose mispredict = 1; that slot is included in the count.
  - Scan stops after a retiring slot whose halt = 1; that slot is included in the count.
- num_retiring equals the number of retiring slots.
- For each retiring slot with has_dest = 1 and R_dest != 0:
  - free_valid[i] = 1, free_preg[i] = T_old.
  - amt_we[i] = 1, amt_idx[i] = R_dest, amt_preg[i] = T.
- All other slots drive 0 on free_valid, amt_we and the data buses.
- Writes to the same R_dest in one cycle: the map table applies higher index last. amt_we is still raised per slot.
- State transitions:
  - A retiring halt moves RUN to HALT. Halt has priority if the same slot also has mispredict set.
  - Otherwise a retiring mispredict moves RUN to FLUSH.
  - Otherwise the FSM stays in RUN.
- FLUSH: num_retiring = 0; all strobes are 0; flush = 1; the next state is RUN unconditionally. ROB contents in this cycle are squashed and ignored.
- HALT: num_retiring = 0; all strobes are 0; halted = 1 until reset.
- rob_outputs_valid = 0 gives zero retirement with no state change.

## Timing
- Retire outputs are combinational from rob_outputs and state. The ROB head and free list update at the same posedge.
- flush and halted are flop outputs, valid one cycle after the retiring edge.
- Reset (also mid-FLUSH or in HALT):
  - State becomes RUN; flush = 0; halted = 0.
  - All counters clear to 0.
  - In the reset cycle, num_retiring, free_valid and amt_we are forced to 0.
- num_retiring is always <= rob_outputs_valid and <= N.
- Back-to-back mispredicts are handled as RUN, FLUSH, RUN, FLUSH. There is at most one flush pulse per mispredict.

## Configuration
- RETIRE_STATS_EN defined:
  - Adds outputs retired_count (64 bits) and flush_count (32 bits).
  - retired_count increments by num_retiring each cycle.
  - flush_count increments on each RUN to FLUSH transition.
  - Both clear on reset, wrap modulo 2^width, and hold in HALT.
- RETIRE_STATS_EN undefined: those ports and flops are absent; all other behaviour is identical.

## Test plan
- N=3, valid=3, complete=1,1,0 -> num_retiring=2; free_valid=011 for dest slots; amt_we matches.
- valid=3, all complete, slot 1 mispredict -> num_retiring=2; next cycle flush=1 and num_retiring=0 even with complete entries; the cycle after, flush=0 and retirement resumes.
- Slot 0 has halt=1 and mispredict=1 -> num_retiring=1; halted=1 next cycle, flush stays 0; num_retiring=0 for 10 cycles; reset clears halted.
- Slot with R_dest=0 or has_dest=0 retires -> counted in num_retiring; free_valid and amt_we for that slot are 0.
- Reset asserted during the FLUSH cycle -> next cycle state RUN, flush=0; with RETIRE_STATS_EN, counts are 0.
- valid=0 for 5 cycles, then valid=2, both complete -> num_retiring=0 throughout, then 2; retired_count=2.
